// File: rtl/router_pkg.sv
// Packet format constants shared by the port receiver and sender.
// A packet is DST, SIZE, n data bytes and a CRC byte (XOR of everything before it).
package router_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   localparam int         OFS_DST     = 0;
   localparam int         OFS_SIZE    = 1;
   localparam logic [2:0] SIZE_MASK   = 3'b111;
   localparam int         HDR_CRC_OVH = 3;

   // A zero SIZE field encodes the maximum of 8 data bytes.
   function automatic logic [3:0] pkt_len(input logic [2:0] size_field);
      logic [2:0] n;
      n = size_field & SIZE_MASK;
      if (n == 3'd0) begin
         pkt_len = 4'd8 + 4'(HDR_CRC_OVH);
      end else begin
         pkt_len = {1'b0, n} + 4'(HDR_CRC_OVH);
      end
   endfunction

endpackage

// File: rtl/port_packet_sender.sv
// Port output stage: replays committed packets from the port buffer as a
// valid/ready byte stream, checking the XOR CRC and releasing the slot at the end.
module port_packet_sender
   import router_pkg::*;
#(
   parameter int PTR_IN_SZ = 4,
   parameter int UWIDTH    = 8
) (
   input  logic                 clk1,
   input  logic                 rst,
   input  logic                 rempty_i,
   output logic [PTR_IN_SZ-1:0] raddr_o,
   input  logic [UWIDTH-1:0]    rdata_i,
   output logic                 rinc_o,
   output logic [UWIDTH-1:0]    pdata_o,
   output logic                 packet_valid_o,
   input  logic                 read_enb_i,
   output logic                 crc_err_o,
   output logic                 busy_o
);

   localparam logic [3:0]           IDX_DST  = 4'(OFS_DST);
   localparam logic [3:0]           IDX_SIZE = 4'(OFS_SIZE);
   localparam logic [PTR_IN_SZ-1:0] ADDR_ONE = {{(PTR_IN_SZ-1){1'b0}}, 1'b1};

   function automatic logic [UWIDTH-1:0] crc_step(input logic [UWIDTH-1:0] acc,
                                                  input logic [UWIDTH-1:0] b);
      crc_step = acc ^ b;
   endfunction

   state_t                 state_r, state_s;
   logic [PTR_IN_SZ-1:0]   raddr_r, raddr_s;
   logic [UWIDTH-1:0]      pdata_r, pdata_s;
   logic [UWIDTH-1:0]      crc_r, crc_s;
   logic [3:0]             idx_r, idx_s;
   logic [3:0]             len_r, len_s;
   logic                   valid_r, valid_s;
   logic                   rinc_r, rinc_s;
   logic                   crc_err_r, crc_err_s;
   logic                   accept_s;
   logic [3:0]             len_eff_s;
   logic                   last_s;
   logic                   crc_next_s;

   // Length is only known once SIZE sits in pdata, so decode it on that byte.
   assign accept_s   = valid_r & read_enb_i;
   assign len_eff_s  = (idx_r == IDX_SIZE) ? pkt_len(pdata_r[2:0]) : len_r;
   assign last_s     = (idx_r > IDX_SIZE) && (idx_r == len_eff_s - 4'd1);
   assign crc_next_s = (idx_r > IDX_SIZE) && (idx_r == len_eff_s - 4'd2);

   // FSM state register.
   always_ff @(posedge clk1) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and datapath decode; the accumulator never absorbs the CRC byte.
   always_comb begin
      state_s   = state_r;
      raddr_s   = raddr_r;
      pdata_s   = pdata_r;
      crc_s     = crc_r;
      idx_s     = idx_r;
      len_s     = len_r;
      valid_s   = valid_r;
      rinc_s    = 1'b0;
      crc_err_s = 1'b0;
      case (state_r)
         IDLE: begin
            raddr_s = '0;
            if (!rempty_i) begin
               state_s = LOAD;
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            pdata_s = rdata_i;
            valid_s = 1'b1;
            crc_s   = rdata_i;
            idx_s   = IDX_DST;
            len_s   = 4'd0;
            raddr_s = ADDR_ONE;
            state_s = SEND;
         end
         SEND: begin
            if (accept_s) begin
               len_s = len_eff_s;
               if (last_s) begin
                  valid_s   = 1'b0;
                  rinc_s    = 1'b1;
                  crc_err_s = (pdata_r != crc_r);
                  raddr_s   = '0;
                  idx_s     = 4'd0;
                  state_s   = IDLE;
               end else begin
                  pdata_s = rdata_i;
                  raddr_s = raddr_r + ADDR_ONE;
                  idx_s   = idx_r + 4'd1;
                  if (crc_next_s) begin
                     crc_s = crc_r;
                  end else begin
                     crc_s = crc_step(crc_r, rdata_i);
                  end
               end
            end else begin
               state_s = SEND;
            end
         end
         default: begin
            state_s = IDLE;
            valid_s = 1'b0;
            raddr_s = '0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk1) begin
      if (!rst) begin
         raddr_r   <= '0;
         pdata_r   <= '0;
         crc_r     <= '0;
         idx_r     <= 4'd0;
         len_r     <= 4'd0;
         valid_r   <= 1'b0;
         rinc_r    <= 1'b0;
         crc_err_r <= 1'b0;
      end else begin
         raddr_r   <= raddr_s;
         pdata_r   <= pdata_s;
         crc_r     <= crc_s;
         idx_r     <= idx_s;
         len_r     <= len_s;
         valid_r   <= valid_s;
         rinc_r    <= rinc_s;
         crc_err_r <= crc_err_s;
      end
   end

   assign raddr_o        = raddr_r;
   assign pdata_o        = pdata_r;
   assign packet_valid_o = valid_r;
   assign rinc_o         = rinc_r;
   assign crc_err_o      = crc_err_r;
   assign busy_o         = (state_r != IDLE);

endmodule

// File: tb/tb_port_packet_sender.sv
// Directed bench for port_packet_sender: a buffer array feeds rdata_i and each
// packet's output stream, handshake timing and CRC flag are checked against it.
module tb_port_packet_sender;

   logic       clk1 = 1'b0;
   logic       rst;
   logic       rempty_i;
   logic [3:0] raddr_o;
   logic [7:0] rdata_i;
   logic       rinc_o;
   logic [7:0] pdata_o;
   logic       packet_valid_o;
   logic       read_enb_i;
   logic       crc_err_o;
   logic       busy_o;

   logic [7:0] mem [16];
   int         total = 0;
   int         bad   = 0;

   port_packet_sender #(.PTR_IN_SZ(4), .UWIDTH(8)) dut (
      .clk1           (clk1),
      .rst            (rst),
      .rempty_i       (rempty_i),
      .raddr_o        (raddr_o),
      .rdata_i        (rdata_i),
      .rinc_o         (rinc_o),
      .pdata_o        (pdata_o),
      .packet_valid_o (packet_valid_o),
      .read_enb_i     (read_enb_i),
      .crc_err_o      (crc_err_o),
      .busy_o         (busy_o)
   );

   always #5 clk1 = ~clk1;
   assign rdata_i = mem[raddr_o];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
   endtask

   // Run one packet of nb bytes from mem[0..nb-1]; bp selects the 1,0,0 ready pattern.
   task automatic run_pkt(input int nb, input bit bp, input logic exp_err);
      int         got = 0, rincs = 0, first = -1, last = -1, k = 0;
      bit         stalled = 1'b0, done = 1'b0, seen_last_addr = 1'b0;
      logic [7:0] pd = 8'h00;
      logic [3:0] pa = 4'h0;
      rempty_i   = 1'b0;
      read_enb_i = 1'b1;
      for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
         @(posedge clk1); #1;
         if (busy_o) rempty_i = 1'b1;
         if (stalled) begin
            check("stall_data", pdata_o, pd);
            check("stall_addr", raddr_o, pa);
            check("stall_valid", packet_valid_o, 1);
         end
         stalled = 1'b0;
         if (raddr_o == 4'(nb - 1)) seen_last_addr = 1'b1;
         if (rinc_o) begin
            rincs++;
            check("crc_err", crc_err_o, exp_err);
            check("rinc_excl", packet_valid_o, 0);
            check("raddr_end", raddr_o, 0);
            done = 1'b1;
         end else if (packet_valid_o) begin
            if (first < 0) first = cyc;
            read_enb_i = bp ? (k % 3 == 0) : 1'b1;
            k++;
            if (read_enb_i) begin
               if (got < nb) check("byte", pdata_o, mem[got]);
               got++;
               last = cyc;
            end else begin
               stalled = 1'b1;
               pd = pdata_o;
               pa = raddr_o;
            end
         end else if (first >= 0) begin
            check("valid_gap", packet_valid_o, 1);
         end
      end
      read_enb_i = 1'b1;
      check("nbytes", got, nb);
      check("rinc_cnt", rincs, 1);
      check("addr_seen", seen_last_addr, 1);
      if (!bp) begin
         check("latency", first, 2);
         check("burst", last - first, nb - 1);
      end
      @(posedge clk1); #1;
      check("gap_busy", busy_o, 0);
      check("gap_rinc", rinc_o, 0);
      check("gap_valid", packet_valid_o, 0);
   endtask

   task automatic load_nominal(input logic [7:0] crc);
      clear_mem();
      mem[0] = 8'h10; mem[1] = 8'h03; mem[2] = 8'hA1;
      mem[3] = 8'hB2; mem[4] = 8'hC3; mem[5] = crc;
   endtask

   initial begin
      int got;
      rst        = 1'b0;
      rempty_i   = 1'b1;
      read_enb_i = 1'b1;
      clear_mem();

      // 1: reset then idle
      repeat (2) @(posedge clk1);
      #1;
      check("rst_valid", packet_valid_o, 0);
      check("rst_rinc", rinc_o, 0);
      check("rst_err", crc_err_o, 0);
      check("rst_pdata", pdata_o, 0);
      check("rst_raddr", raddr_o, 0);
      check("rst_busy", busy_o, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk1);
      #1;
      check("idle_busy", busy_o, 0);
      check("idle_valid", packet_valid_o, 0);

      // 2: nominal packet, CRC = 10^03^A1^B2^C3 = C3
      load_nominal(8'hC3);
      run_pkt(6, 1'b0, 1'b0);

      // 3: bad CRC still forwarded
      load_nominal(8'h00);
      run_pkt(6, 1'b0, 1'b1);

      // 4: backpressure 1,0,0,...
      load_nominal(8'hC3);
      run_pkt(6, 1'b1, 1'b0);

      // 5: SIZE=00 -> 8 data bytes, CRC = 22^00^(01..08) = 2A
      clear_mem();
      mem[0] = 8'h22; mem[1] = 8'h00;
      for (int i = 0; i < 8; i++) mem[2 + i] = 8'(i + 1);
      mem[10] = 8'h2A;
      run_pkt(11, 1'b0, 1'b0);

      // SIZE upper bits ignored: F9 -> 1 data byte, CRC = 5A^F9^77 = D4
      clear_mem();
      mem[0] = 8'h5A; mem[1] = 8'hF9; mem[2] = 8'h77; mem[3] = 8'hD4;
      run_pkt(4, 1'b0, 1'b0);

      // 6: reset after the 3rd byte, then resend from DST
      load_nominal(8'hC3);
      rempty_i = 1'b0;
      got = 0;
      for (int cyc = 0; cyc < 50 && got < 3; cyc++) begin
         @(posedge clk1); #1;
         if (busy_o) rempty_i = 1'b1;
         if (packet_valid_o) got++;
      end
      check("pre_rst_bytes", got, 3);
      @(posedge clk1); #1;
      rst = 1'b0;
      @(posedge clk1); #1;
      check("mid_rst_valid", packet_valid_o, 0);
      check("mid_rst_rinc", rinc_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_raddr", raddr_o, 0);
      rst = 1'b1;
      run_pkt(6, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
